mac_cluster_seq: RTL and testbench
==================================

Name: mac_cluster_seq

Overview:
Job sequencer in front of one quad MAC cluster. Accepts a job descriptor (mode config, four initial accumulator values, beat count), then:
- loads the cluster,
- streams operand beats into it under valid/ready with back-pressure,
- drains the cluster pipeline,
- captures the four cluster outputs and presents them as one result beat with a lane-valid mask.

Sits between the fabric-side job/operand/result streams and the cluster's clk/rst/en/A/B/cfg/out pins.

Parameters:
- MIN_W, 8, operand width (A*/B* lanes)
- ACC_W, 32, accumulator/output width per lane
- CONF_W, 8, cluster config bits; bits [1:0] = mode
- LEN_W, 16, beat-count width
- LAT, 3, cluster pipeline depth in enabled cycles (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- job_valid  in  1  descriptor valid
- job_ready  out  1  descriptor accepted when both high
- job_cfg  in  4*ACC_W+CONF_W  {init3,init2,init1,init0,conf}
- job_len  in  LEN_W  number of operand beats
- op_valid  in  1  operand beat valid
- op_ready  out  1  operand beat accepted when both high
- op_a  in  4*MIN_W  {A3,A2,A1,A0}
- op_b  in  4*MIN_W  {B3,B2,B1,B0}
- res_valid  out  1  result valid
- res_ready  in  1  result consumed when both high
- res_data  out  4*ACC_W  {out3,out2,out1,out0}
- res_mask  out  4  lanes carrying a meaningful result
- res_err  out  1  reserved mode seen in this job
- mac_rst  out  1  cluster reset/load strobe
- mac_en  out  1  cluster enable
- mac_a, mac_b  out  4*MIN_W each  cluster operands
- mac_cfg  out  4*ACC_W+CONF_W  cluster config, stable for the whole job
- mac_out  in  4*ACC_W  {out3..out0} from cluster
- perf_busy, perf_stall  out  32 each  see Optional Feature

Behaviour:
- Clocking and reset: single clock domain, clk; rst is synchronous, active-high, and fully resets the block.
- Reset values: state=IDLE; job_ready=1; op_ready=0; res_valid=0; res_data=0; res_mask=0; res_err=0; mac_rst=1 (cluster held in reset); mac_en=0; mac_a=mac_b=0; mac_cfg=0.
- IDLE:
  - job_ready=1.
  - On job_valid: register job_cfg into mac_cfg, job_len into remaining counter.
  - Set err=(conf[1:0]==2'b11). Go to LOAD.
- LOAD (exactly 1 cycle):
  - mac_rst=1, so the cluster loads init values from mac_cfg.
  - Next state is RUN if remaining!=0, else DRAIN.
- RUN:
  - op_ready=1.
  - Accept = op_valid&op_ready. On accept, mac_en=1, mac_a=op_a, mac_b=op_b (combinational pass-through), and remaining decrements.
  - No accept -> mac_en=0; operands are don't-care but driven 0.
  - Accepting the last beat (remaining==1) moves to DRAIN next cycle.
- DRAIN:
  - LAT cycles with mac_en=1, mac_a=mac_b=0 (zero products, accumulators unchanged), drain counter counting LAT-1..0.
  - At 0, capture mac_out into res_data next cycle. Go to RESULT.
- RESULT:
  - res_valid=1; res_data, res_mask and res_err are held stable until res_ready.
  - On res_ready: res_valid=0 next cycle and state returns to IDLE.
  - job_ready stays 0 until back in IDLE; no job overlap.
- res_mask by mode:
  - 00 single = 4'b1111
  - 01 dual = 4'b0101
  - 10 quad = 4'b0001
  - 11 reserved = 4'b1111, treated as single, res_err=1
- Latency: job accept to res_valid = 1 (LOAD) + N accepted beats (+ stalls) + LAT + 1 cycles.
  - N=0 gives LAT+2.
- Handshake rules:
  - job_ready, op_ready and res_valid are registered-state derived only. No combinational path from res_ready to any output other than through state.
  - op_ready is never high outside RUN.
- Reset mid-job: any state returns to IDLE with reset values on the next edge. Partial results are discarded and no res_valid is emitted.
- Counters: remaining counter never wraps, since decrement happens only on accept with remaining>0. job_len=2^LEN_W-1 is legal.

Optional Feature:
Macro MAC_SEQ_PERF_EN.
- Defined:
  - perf_busy increments every cycle state!=IDLE.
  - perf_stall increments every RUN cycle with op_valid=0.
  - Both reset to 0 on rst and saturate at 32'hFFFFFFFF.
- Undefined: both ports tied to 0, no counter logic.

Test Plan:
- Quad-mode dot product: conf=8'h02, inits=0, len=4, beats A0=1..4 with B0=1 each (other lanes 0) -> res_valid after 4+LAT+2 cycles; lane0 holds cluster sum 10; res_mask=4'b0001; res_err=0.
- Single mode with nonzero inits: init={40,30,20,10}, len=2, A=B=2 in all lanes -> out_i=init_i+8; res_mask=4'b1111.
- Back-pressure: len=3, op_valid toggled 1,0,0,1,0,1 -> exactly 3 mac_en pulses during RUN; perf_stall=3 when MAC_SEQ_PERF_EN is defined; results match the unstalled run.
- Zero length and reserved mode: len=0, conf=8'h03 -> res_valid LAT+2 cycles after accept, res_data=inits, res_err=1, res_mask=4'b1111.
- Result hold: res_ready=0 for 10 cycles -> res_valid and res_data constant; job_ready=0; a second job is accepted only the cycle after res_ready.
- Reset mid-RUN after 2 of 5 beats -> next cycle IDLE, job_ready=1, mac_rst=1, no res_valid; a fresh job then completes correctly.

Source files
------------

// File: rtl/mac_cluster_seq.sv
// mac_cluster_seq: job sequencer in front of one quad MAC cluster.
// Takes a job descriptor, loads the cluster, streams operand beats into it,
// drains the pipeline and returns the four lane results as one result beat.
// Optional cycle counters on perf_busy/perf_stall: define MAC_SEQ_PERF_EN.
module mac_cluster_seq #(
  parameter int unsigned MIN_W  = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned CONF_W = 8,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned LAT    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [4*ACC_W+CONF_W-1:0] job_cfg,
  input  logic [LEN_W-1:0]          job_len,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [4*MIN_W-1:0]        op_a,
  input  logic [4*MIN_W-1:0]        op_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [4*ACC_W-1:0]        res_data,
  output logic [3:0]                res_mask,
  output logic                      res_err,
  output logic                      mac_rst,
  output logic                      mac_en,
  output logic [4*MIN_W-1:0]        mac_a,
  output logic [4*MIN_W-1:0]        mac_b,
  output logic [4*ACC_W+CONF_W-1:0] mac_cfg,
  input  logic [4*ACC_W-1:0]        mac_out,
  output logic [31:0]               perf_busy,
  output logic [31:0]               perf_stall
);

  localparam int unsigned OPS_W = 4 * MIN_W;
  localparam int unsigned DRN_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_CAPT,
    S_RESULT
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [LEN_W-1:0]   remaining;
  logic [DRN_W-1:0]   drain_cnt;
  logic               err_q;
  logic               job_fire;
  logic               op_fire;

  // Lane-valid mask for a cluster mode; the reserved mode behaves as single.
  function automatic logic [3:0] mode_mask(input logic [1:0] mode);
    case (mode)
      2'b01:   return 4'b0101;
      2'b10:   return 4'b0001;
      default: return 4'b1111;
    endcase
  endfunction

  assign job_fire = (state == S_IDLE) && job_valid;
  assign op_fire  = (state == S_RUN) && op_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the cluster drive that must follow op_valid in the same cycle.
  always_comb begin
    state_next = state;
    mac_en     = 1'b0;
    mac_a      = '0;
    mac_b      = '0;
    case (state)
      S_IDLE: begin
        if (job_valid) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        state_next = (remaining != '0) ? S_RUN : S_DRAIN;
      end
      S_RUN: begin
        if (op_fire) begin
          mac_en = 1'b1;
          mac_a  = op_a;
          mac_b  = op_b;
          if (remaining == LEN_W'(1)) begin
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Zero operands push the last real products through the pipeline.
        mac_en = 1'b1;
        mac_a  = OPS_W'(0);
        mac_b  = OPS_W'(0);
        if (drain_cnt == '0) begin
          state_next = S_CAPT;
        end
      end
      S_CAPT: begin
        state_next = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Registered handshakes, job registers, counters and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      job_ready <= 1'b1;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
      mac_rst   <= 1'b1;
      mac_cfg   <= '0;
      remaining <= '0;
      drain_cnt <= '0;
      err_q     <= 1'b0;
      res_data  <= '0;
      res_mask  <= '0;
      res_err   <= 1'b0;
    end else begin
      job_ready <= (state_next == S_IDLE);
      op_ready  <= (state_next == S_RUN);
      res_valid <= (state_next == S_RESULT);
      mac_rst   <= (state_next == S_IDLE) || (state_next == S_LOAD);

      if (job_fire) begin
        mac_cfg   <= job_cfg;
        remaining <= job_len;
        err_q     <= (job_cfg[1:0] == 2'b11);
      end else if (op_fire && (remaining != '0)) begin
        remaining <= remaining - LEN_W'(1);
      end

      if ((state_next == S_DRAIN) && (state != S_DRAIN)) begin
        drain_cnt <= DRN_W'(LAT - 1);
      end else if ((state == S_DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - DRN_W'(1);
      end

      // The last drain edge lands in the cluster output register; sample it one cycle later.
      if (state == S_CAPT) begin
        res_data <= mac_out;
        res_mask <= mode_mask(mac_cfg[1:0]);
        res_err  <= err_q;
      end
    end
  end

`ifdef MAC_SEQ_PERF_EN
  // Saturating busy and operand-starvation counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if ((state != S_IDLE) && (perf_busy != 32'hFFFF_FFFF)) begin
        perf_busy <= perf_busy + 32'd1;
      end
      if ((state == S_RUN) && !op_valid && (perf_stall != 32'hFFFF_FFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`else
  assign perf_busy  = 32'd0;
  assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_mac_cluster_seq.sv
// Bench for mac_cluster_seq: directed jobs against a behavioural quad MAC
// cluster, with expected results queued at job issue and checked by a monitor.
module tb_mac_cluster_seq;

  localparam int unsigned MIN_W  = 8;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned CONF_W = 8;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned LAT    = 3;
  localparam int unsigned CFG_W  = 4 * ACC_W + CONF_W;

  logic               clk;
  logic               rst;
  logic               job_valid;
  logic               job_ready;
  logic [CFG_W-1:0]   job_cfg;
  logic [LEN_W-1:0]   job_len;
  logic               op_valid;
  logic               op_ready;
  logic [4*MIN_W-1:0] op_a;
  logic [4*MIN_W-1:0] op_b;
  logic               res_valid;
  logic               res_ready;
  logic [4*ACC_W-1:0] res_data;
  logic [3:0]         res_mask;
  logic               res_err;
  logic               mac_rst;
  logic               mac_en;
  logic [4*MIN_W-1:0] mac_a;
  logic [4*MIN_W-1:0] mac_b;
  logic [CFG_W-1:0]   mac_cfg;
  logic [4*ACC_W-1:0] mac_out;
  logic [31:0]        perf_busy;
  logic [31:0]        perf_stall;

  mac_cluster_seq #(
    .MIN_W(MIN_W), .ACC_W(ACC_W), .CONF_W(CONF_W), .LEN_W(LEN_W), .LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_cfg(job_cfg), .job_len(job_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_mask(res_mask), .res_err(res_err),
    .mac_rst(mac_rst), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_cfg(mac_cfg), .mac_out(mac_out),
    .perf_busy(perf_busy), .perf_stall(perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural cluster: LAT enabled cycles from operands to accumulator output.
  logic [ACC_W-1:0] prod [4];
  logic [ACC_W-1:0] lane_sum [4];
  logic [ACC_W-1:0] acc [4];
  logic [ACC_W-1:0] st1 [4];
  logic [ACC_W-1:0] st2 [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      prod[i]     = ACC_W'(mac_a[i*MIN_W +: MIN_W]) * ACC_W'(mac_b[i*MIN_W +: MIN_W]);
      lane_sum[i] = '0;
    end
    case (mac_cfg[1:0])
      2'b01: begin
        lane_sum[0] = prod[0] + prod[1];
        lane_sum[2] = prod[2] + prod[3];
      end
      2'b10: lane_sum[0] = prod[0] + prod[1] + prod[2] + prod[3];
      default: for (int i = 0; i < 4; i++) lane_sum[i] = prod[i];
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mac_rst) begin
        acc[i] <= mac_cfg[CONF_W + i*ACC_W +: ACC_W];
        st1[i] <= '0;
        st2[i] <= '0;
      end else if (mac_en) begin
        st1[i] <= lane_sum[i];
        st2[i] <= st1[i];
        acc[i] <= acc[i] + st2[i];
      end
    end
  end

  assign mac_out = {acc[3], acc[2], acc[1], acc[0]};

  typedef struct {
    logic [4*ACC_W-1:0] data;
    logic [3:0]         mask;
    logic               err;
    int                 lat;
    int                 acc_cyc;
  } exp_t;

  exp_t               exp_q[$];
  int                 checks = 0;
  int                 errors = 0;
  int                 accept_cyc = 0;
  int                 run_en_cnt = 0;
  logic [4*MIN_W-1:0] beat_a [8];
  logic [4*MIN_W-1:0] beat_b [8];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  function automatic logic [CFG_W-1:0] mk_cfg(input logic [31:0] i3, input logic [31:0] i2,
                                              input logic [31:0] i1, input logic [31:0] i0,
                                              input logic [7:0] conf);
    return {i3, i2, i1, i0, conf};
  endfunction

  function automatic logic [4*ACC_W-1:0] mk_res(input logic [31:0] o3, input logic [31:0] o2,
                                               input logic [31:0] o1, input logic [31:0] o0);
    return {o3, o2, o1, o0};
  endfunction

  task automatic push_exp(input logic [4*ACC_W-1:0] d, input logic [3:0] m, input logic e,
                          input int lat);
    exp_t x;
    x.data = d; x.mask = m; x.err = e; x.lat = lat; x.acc_cyc = accept_cyc;
    exp_q.push_back(x);
  endtask

  // Present a descriptor; returns on the negedge after the accepting edge.
  task automatic issue_job(input logic [CFG_W-1:0] cfg, input logic [LEN_W-1:0] len);
    int g = 0;
    while (!job_ready && g < 100) begin @(negedge clk); g++; end
    if (!job_ready) fail_now("job_ready_wait");
    job_valid = 1'b1; job_cfg = cfg; job_len = len;
    @(negedge clk);
    job_valid = 1'b0;
    accept_cyc = cyc;
  endtask

  // Drive one op_valid slot per cycle from pat, advancing beats only on accept.
  task automatic drive_ops(input int nslots, input logic [15:0] pat);
    int g = 0;
    int k = 0;
    while (!op_ready && g < 50) begin @(negedge clk); g++; end
    if (!op_ready) fail_now("op_ready_wait");
    for (int s = 0; s < nslots; s++) begin
      op_valid = pat[s]; op_a = beat_a[k]; op_b = beat_b[k];
      if (op_valid && op_ready) k++;
      @(negedge clk);
    end
    op_valid = 1'b0; op_a = '0; op_b = '0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (exp_q.size() != 0 && g < 300) begin @(negedge clk); g++; end
    if (exp_q.size() != 0) begin
      fail_now("result_wait");
      exp_q.delete();
    end
  endtask

  // Scoreboard monitor: latency on res_valid rise, payload on handshake.
  task automatic monitor();
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mac_en && op_ready) run_en_cnt++;
      if (res_valid && !prev) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_res_valid");
        end else if (exp_q[0].lat >= 0) begin
          chk("latency", 160'(cyc - exp_q[0].acc_cyc), 160'(exp_q[0].lat));
        end
      end
      if (res_valid && res_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
          if (e.mask[i]) begin
            chk($sformatf("res_lane%0d", i), 160'(res_data[i*ACC_W +: ACC_W]),
                160'(e.data[i*ACC_W +: ACC_W]));
          end
        end
        chk("res_mask", 160'(res_mask), 160'(e.mask));
        chk("res_err", 160'(res_err), 160'(e.err));
      end
      prev = res_valid;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
`ifdef MAC_SEQ_PERF_EN
    logic [31:0] pb0;
    logic [31:0] ps0;
`endif
    int g;
    rst = 1'b1; job_valid = 1'b0; job_cfg = '0; job_len = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_job_ready", 160'(job_ready), 160'(1));
    chk("rst_op_ready", 160'(op_ready), 160'(0));
    chk("rst_res_valid", 160'(res_valid), 160'(0));
    chk("rst_res_data", 160'(res_data), 160'(0));
    chk("rst_res_mask", 160'(res_mask), 160'(0));
    chk("rst_res_err", 160'(res_err), 160'(0));
    chk("rst_mac_rst", 160'(mac_rst), 160'(1));
    chk("rst_mac_en", 160'(mac_en), 160'(0));
    chk("rst_mac_ab", 160'({mac_a, mac_b}), 160'(0));
    chk("rst_mac_cfg", 160'(mac_cfg), 160'(0));
    chk("rst_perf", 160'({perf_busy, perf_stall}), 160'(0));
    rst = 1'b0;
    @(negedge clk);

    // Quad-mode dot product: 1+2+3+4 into lane 0.
    for (int k = 0; k < 4; k++) begin
      beat_a[k] = {24'd0, 8'(k + 1)};
      beat_b[k] = 32'd1;
    end
    issue_job(mk_cfg(0, 0, 0, 0, 8'h02), 16'd4);
    push_exp(mk_res(0, 0, 0, 10), 4'b0001, 1'b0, 4 + LAT + 2);
    drive_ops(4, 16'h000F);
    wait_done();

    // Single mode with nonzero inits: each lane gains 2*(2*2).
    for (int k = 0; k < 2; k++) begin
      beat_a[k] = 32'h0202_0202;
      beat_b[k] = 32'h0202_0202;
    end
    issue_job(mk_cfg(40, 30, 20, 10, 8'h00), 16'd2);
    push_exp(mk_res(48, 38, 28, 18), 4'b1111, 1'b0, 2 + LAT + 2);
    drive_ops(2, 16'h0003);
    wait_done();

    // Back-pressure: op_valid 1,0,0,1,0,1; lanes get 2*(1+2+3).
    for (int k = 0; k < 3; k++) begin
      beat_a[k] = {4{8'(k + 1)}};
      beat_b[k] = 32'h0202_0202;
    end
`ifdef MAC_SEQ_PERF_EN
    pb0 = perf_busy;
    ps0 = perf_stall;
`endif
    run_en_cnt = 0;
    issue_job(mk_cfg(0, 0, 0, 0, 8'h00), 16'd3);
    push_exp(mk_res(12, 12, 12, 12), 4'b1111, 1'b0, 1 + 6 + LAT + 1);
    drive_ops(6, 16'h0029);
    wait_done();
    chk("run_mac_en_pulses", 160'(run_en_cnt), 160'(3));
`ifdef MAC_SEQ_PERF_EN
    chk("perf_stall_delta", 160'(perf_stall - ps0), 160'(3));
    chk("perf_busy_delta", 160'(perf_busy - pb0), 160'(12));
`endif

    // Same job without stalls must give the same result.
    issue_job(mk_cfg(0, 0, 0, 0, 8'h00), 16'd3);
    push_exp(mk_res(12, 12, 12, 12), 4'b1111, 1'b0, 3 + LAT + 2);
    drive_ops(3, 16'h0007);
    wait_done();

    // Zero length, reserved mode: inits come straight back with the error flag.
    issue_job(mk_cfg(4, 3, 2, 1, 8'h03), 16'd0);
    push_exp(mk_res(4, 3, 2, 1), 4'b1111, 1'b1, LAT + 2);
    wait_done();

    // Result hold under res_ready=0, with a second job already waiting.
    res_ready = 1'b0;
    beat_a[0] = 32'h0303_0303;
    beat_b[0] = 32'h0505_0505;
    issue_job(mk_cfg(0, 0, 0, 0, 8'h00), 16'd1);
    push_exp(mk_res(15, 15, 15, 15), 4'b1111, 1'b0, 1 + LAT + 2);
    drive_ops(1, 16'h0001);
    g = 0;
    while (!res_valid && g < 50) begin @(negedge clk); g++; end
    if (!res_valid) fail_now("hold_res_valid_wait");
    job_valid = 1'b1; job_cfg = mk_cfg(8, 7, 6, 5, 8'h01); job_len = 16'd0;
    for (int h = 0; h < 10; h++) begin
      chk("hold_res_valid", 160'(res_valid), 160'(1));
      chk("hold_res_data", 160'(res_data), 160'(mk_res(15, 15, 15, 15)));
      chk("hold_job_ready", 160'(job_ready), 160'(0));
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_job_ready", 160'(job_ready), 160'(1));
    chk("post_hs_res_valid", 160'(res_valid), 160'(0));
    issue_job(mk_cfg(8, 7, 6, 5, 8'h01), 16'd0);
    push_exp(mk_res(8, 7, 6, 5), 4'b0101, 1'b0, LAT + 2);
    wait_done();

    // Dual mode with data: lane0 = 1+2, lane2 = 3+4.
    beat_a[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    beat_b[0] = 32'h0101_0101;
    issue_job(mk_cfg(0, 0, 0, 0, 8'h01), 16'd1);
    push_exp(mk_res(0, 7, 0, 3), 4'b0101, 1'b0, 1 + LAT + 2);
    drive_ops(1, 16'h0001);
    wait_done();

    // Reset after 2 of 5 beats: job is dropped without a result.
    for (int k = 0; k < 5; k++) begin
      beat_a[k] = 32'h0101_0101;
      beat_b[k] = 32'h0101_0101;
    end
    issue_job(mk_cfg(0, 0, 0, 0, 8'h00), 16'd5);
    drive_ops(2, 16'h0003);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_job_ready", 160'(job_ready), 160'(1));
    chk("midrst_mac_rst", 160'(mac_rst), 160'(1));
    chk("midrst_op_ready", 160'(op_ready), 160'(0));
    chk("midrst_mac_en", 160'(mac_en), 160'(0));
    chk("midrst_res_valid", 160'(res_valid), 160'(0));
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_idle_res_valid", 160'(res_valid), 160'(0));

    // Fresh job after the reset.
    issue_job(mk_cfg(0, 0, 0, 0, 8'h00), 16'd1);
    push_exp(mk_res(1, 1, 1, 1), 4'b1111, 1'b0, 1 + LAT + 2);
    drive_ops(1, 16'h0001);
    wait_done();

`ifndef MAC_SEQ_PERF_EN
    chk("perf_tied_off", 160'({perf_busy, perf_stall}), 160'(0));
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
